neogeo_lock_ctrl: RTL

NEOGEO_LOCK_CTRL -- requirements
Module: neogeo_lock_ctrl

---
 rtl/neogeo_pkg.sv | 21 ++
 rtl/neogeo_tol_cmp.sv | 23 ++
 rtl/neogeo_lock_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/neogeo_pkg.sv
// Shared definitions for the video timing lock controller: FSM encoding,
// parameter defaults and the lock-frame target helper.
package neogeo_pkg;

   typedef enum logic [1:0] {
      ST_NOSIG    = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_RECONFIG = 2'd2,
      ST_LOCKED   = 2'd3
   } lock_state_e;

   localparam int LOCK_MISS_MAX_DEF = 3;
   localparam int WDOG_LIMIT_DEF    = 4194303;
   localparam int FRAME_W           = 22;

   // A configured lock-frame count of zero is treated as one.
   function automatic logic [3:0] lock_target(input logic [3:0] cfg);
      return (cfg == 4'd0) ? 4'd1 : cfg;
   endfunction

endpackage

// File: rtl/neogeo_tol_cmp.sv
// Combinational |a - b| <= tol check on 22-bit frame lengths, computed in
// 23-bit arithmetic so the difference never wraps.
module neogeo_tol_cmp
   import neogeo_pkg::*;
(
   input  logic [FRAME_W-1:0] a_i,
   input  logic [FRAME_W-1:0] b_i,
   input  logic [7:0]         tol_i,
   output logic               match_o
);

   logic [FRAME_W:0] diff;

   always_comb begin
      if (a_i >= b_i) begin
         diff = {1'b0, a_i} - {1'b0, b_i};
      end else begin
         diff = {1'b0, b_i} - {1'b0, a_i};
      end
      match_o = (diff <= {{(FRAME_W - 7){1'b0}}, tol_i});
   end

endmodule

// File: rtl/neogeo_lock_ctrl.sv
// Frame timing lock controller: acquires a stable frame length, handshakes a
// downstream reconfiguration, then tracks lock with miss and watchdog checks.
module neogeo_lock_ctrl
   import neogeo_pkg::*;
#(
   parameter int LOCK_MISS_MAX = LOCK_MISS_MAX_DEF,
   parameter int WDOG_LIMIT    = WDOG_LIMIT_DEF
) (
   input  logic         VCLK_i,
   input  logic         RESET_i,
   input  logic         frame_change_i,
   input  logic [21:0]  vclks_per_frame_i,
   input  logic [7:0]   cfg_tol_i,
   input  logic [3:0]   cfg_lock_frames_i,
   input  logic         reconfig_ack_i,
   output logic         reconfig_req_o,
   output logic         locked_o,
   output logic [1:0]   state_o,
   output logic [21:0]  vclks_ref_o,
   output logic [7:0]   unlock_cnt_o
);

   localparam int                WDOG_W   = $clog2(WDOG_LIMIT + 1);
   localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);
   localparam logic [7:0]        MISS_MAX = 8'(LOCK_MISS_MAX);

   lock_state_e       state_q, state_d;
   logic              fc_q;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic [21:0]       ref_q, ref_d;
   logic [21:0]       vref_q, vref_d;
   logic [3:0]        match_q, match_d;
   logic [7:0]        miss_q, miss_d;
   logic [7:0]        unlock_q, unlock_d;
   logic              locked_q, locked_d;
   logic              req_q, req_d;

   logic              frame_edge;
   logic              wdog_expire;
   logic              frame_match;
   logic [3:0]        match_inc;
   logic [7:0]        miss_inc;

   assign frame_edge  = frame_change_i & ~fc_q;
   // An edge in the expiry cycle takes priority and restarts the count.
   assign wdog_expire = ~frame_edge & (wdog_q == WDOG_MAX);
   assign match_inc   = match_q + 4'd1;
   assign miss_inc    = miss_q + 8'd1;

   neogeo_tol_cmp u_tol_cmp (
      .a_i     (vclks_per_frame_i),
      .b_i     (ref_q),
      .tol_i   (cfg_tol_i),
      .match_o (frame_match)
   );

   always_ff @(posedge VCLK_i or posedge RESET_i) begin
      if (RESET_i) begin
         state_q <= ST_NOSIG;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      vref_d   = vref_q;
      match_d  = match_q;
      miss_d   = miss_q;
      unlock_d = unlock_q;
      wdog_d   = wdog_q;
      if (frame_edge) begin
         wdog_d = '0;
      end else if (wdog_q != WDOG_MAX) begin
         wdog_d = wdog_q + 1'b1;
      end

      if (wdog_expire) begin
         state_d = ST_NOSIG;
         match_d = '0;
         miss_d  = '0;
      end else begin
         case (state_q)
            ST_NOSIG: begin
               if (frame_edge) begin
                  ref_d   = vclks_per_frame_i;
                  match_d = '0;
                  state_d = ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (frame_edge) begin
                  if (frame_match) begin
                     match_d = match_inc;
                     if (match_inc == lock_target(cfg_lock_frames_i)) begin
                        state_d = ST_RECONFIG;
                        vref_d  = ref_q;
                     end
                  end else begin
                     ref_d   = vclks_per_frame_i;
                     match_d = '0;
                  end
               end
            end
            // req is held until ack is sampled high; ack elsewhere is ignored.
            ST_RECONFIG: begin
               if (reconfig_ack_i) begin
                  state_d = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (frame_edge) begin
                  if (frame_match) begin
                     miss_d = '0;
                  end else if (miss_inc == MISS_MAX) begin
                     state_d = ST_ACQUIRE;
                     ref_d   = vclks_per_frame_i;
                     match_d = '0;
                     miss_d  = '0;
                     if (unlock_q != 8'hFF) begin
                        unlock_d = unlock_q + 8'd1;
                     end
                  end else begin
                     miss_d = miss_inc;
                  end
               end
            end
            default: state_d = ST_NOSIG;
         endcase
      end
   end

   always_comb begin
      locked_d = (state_d == ST_LOCKED);
      req_d    = (state_d == ST_RECONFIG);
   end

   always_ff @(posedge VCLK_i or posedge RESET_i) begin
      if (RESET_i) begin
         fc_q     <= 1'b0;
         wdog_q   <= '0;
         ref_q    <= '0;
         vref_q   <= '0;
         match_q  <= '0;
         miss_q   <= '0;
         unlock_q <= '0;
         locked_q <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         fc_q     <= frame_change_i;
         wdog_q   <= wdog_d;
         ref_q    <= ref_d;
         vref_q   <= vref_d;
         match_q  <= match_d;
         miss_q   <= miss_d;
         unlock_q <= unlock_d;
         locked_q <= locked_d;
         req_q    <= req_d;
      end
   end

   assign state_o        = state_q;
   assign locked_o       = locked_q;
   assign reconfig_req_o = req_q;
   assign vclks_ref_o    = vref_q;
   assign unlock_cnt_o   = unlock_q;

endmodule
